// File: rtl/wdt_rst_seq.sv
// rtl/wdt_rst_seq.sv - watchdog grace-window and held system-reset sequencer
// Optional external reset request input enabled by WDT_RST_SEQ_EXTREQ_EN.
module wdt_rst_seq #(
    parameter int GRACE_WIDTH = 16,
    parameter int HOLD_WIDTH  = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   wdt_rst_i,
    input  logic                   ack_i,
    input  logic [GRACE_WIDTH-1:0] grace_cycles_i,
    input  logic [HOLD_WIDTH-1:0]  hold_cycles_i,
    input  logic                   cause_clear_i,
`ifdef WDT_RST_SEQ_EXTREQ_EN
    input  logic                   ext_rst_req_i,
`endif
    output logic                   irq_o,
    output logic                   sys_rst_o,
    output logic                   busy_o,
    output logic [1:0]             cause_o,
    output logic [CNT_WIDTH-1:0]   rst_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRACE    = 2'd1,
        ASSERT   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [GRACE_WIDTH-1:0] grace_cnt_q, grace_cnt_d;
    logic [HOLD_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
    logic                   cool_q, cool_d;
    logic                   irq_q, irq_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   rst_cnt_q, rst_cnt_d;

    logic                   ext_req;
    logic                   enter_assert;
    logic [1:0]             set_mask;

`ifdef WDT_RST_SEQ_EXTREQ_EN
    assign ext_req = ext_rst_req_i;
`else
    assign ext_req = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grace_cnt_d  = grace_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cool_d       = cool_q;
        rst_cnt_d    = rst_cnt_q;
        irq_d        = 1'b0;
        enter_assert = 1'b0;
        set_mask     = 2'b00;

        case (state_q)
            IDLE: begin
                // External request outranks a coincident watchdog pulse and raises no irq.
                if (en_i && ext_req) begin
                    enter_assert = 1'b1;
                    set_mask     = 2'b10;
                end else if (en_i && wdt_rst_i) begin
                    irq_d = 1'b1;
                    if (grace_cycles_i == '0) begin
                        enter_assert = 1'b1;
                        set_mask     = 2'b01;
                    end else begin
                        state_d     = GRACE;
                        grace_cnt_d = grace_cycles_i;
                    end
                end
            end
            GRACE: begin
                if (wdt_rst_i) begin
                    irq_d        = 1'b1;
                    enter_assert = 1'b1;
                    set_mask     = 2'b01;
                end else if (ack_i || !en_i) begin
                    state_d = IDLE;
                end else if (grace_cnt_q == GRACE_WIDTH'(1)) begin
                    enter_assert = 1'b1;
                    set_mask     = 2'b01;
                end else begin
                    grace_cnt_d = grace_cnt_q - GRACE_WIDTH'(1);
                end
            end
            ASSERT: begin
                if (hold_cnt_q == HOLD_WIDTH'(1)) begin
                    state_d = COOLDOWN;
                    cool_d  = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_WIDTH'(1);
                end
            end
            COOLDOWN: begin
                if (cool_q) begin
                    state_d = IDLE;
                end else begin
                    cool_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_assert) begin
            state_d     = ASSERT;
            grace_cnt_d = '0;
            hold_cnt_d  = (hold_cycles_i == '0) ? HOLD_WIDTH'(1) : hold_cycles_i;
            if (rst_cnt_q != '1) begin
                rst_cnt_d = rst_cnt_q + CNT_WIDTH'(1);
            end
        end

        // A cause being set in this cycle survives a simultaneous clear.
        cause_d   = (cause_clear_i ? 2'b00 : cause_q) | set_mask;
        sys_rst_d = (state_d == ASSERT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grace_cnt_q <= '0;
            hold_cnt_q  <= '0;
            cool_q      <= 1'b0;
            irq_q       <= 1'b0;
            sys_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            cause_q     <= 2'b00;
            rst_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grace_cnt_q <= grace_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            cool_q      <= cool_d;
            irq_q       <= irq_d;
            sys_rst_q   <= sys_rst_d;
            busy_q      <= busy_d;
            cause_q     <= cause_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign irq_o     = irq_q;
    assign sys_rst_o = sys_rst_q;
    assign busy_o    = busy_q;
    assign cause_o   = cause_q;
    assign rst_cnt_o = rst_cnt_q;

endmodule

// File: tb/tb_wdt_rst_seq.sv
// tb/tb_wdt_rst_seq.sv - randomized and directed self-checking bench for wdt_rst_seq
module tb_wdt_rst_seq;

    localparam int GW = 16;
    localparam int HW = 8;
    localparam int CW = 2;
    localparam longint BIG = 64'd1 << 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wdt = 1'b0;
    logic          ack = 1'b0;
    logic [GW-1:0] grace = '0;
    logic [HW-1:0] hold = '0;
    logic          clr = 1'b0;
    logic          ext = 1'b0;
    logic          irq, sys_rst, busy;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wdt_rst_seq #(.GRACE_WIDTH(GW), .HOLD_WIDTH(HW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .wdt_rst_i      (wdt),
        .ack_i          (ack),
        .grace_cycles_i (grace),
        .hold_cycles_i  (hold),
        .cause_clear_i  (clr),
`ifdef WDT_RST_SEQ_EXTREQ_EN
        .ext_rst_req_i  (ext),
`endif
        .irq_o          (irq),
        .sys_rst_o      (sys_rst),
        .busy_o         (busy),
        .cause_o        (cause),
        .rst_cnt_o      (cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: each accepted event is turned into absolute cycle numbers.
    longint cyc = 0;
    longint idle_from = 0, grace_last = -1, rs_start = -10, rs_end = -11, irq_at = -1;
    int     m_cause = 0, m_cnt = 0;
    bit     model_ok = 0;

    task automatic sched(input longint n);
        longint h;
        h          = (hold == 0) ? 1 : longint'(hold);
        rs_start   = n;
        rs_end     = n + h - 1;
        idle_from  = n + h + 2;
        grace_last = -1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    always @(posedge clk) begin
        longint c, n;
        int set;
        c = cyc;
        n = c + 1;
        set = 0;
        if (rst) begin
            idle_from = n; grace_last = -1; rs_start = -10; rs_end = -11;
            irq_at = -1; m_cause = 0; m_cnt = 0; model_ok = 1;
        end else begin
            if (c >= idle_from) begin
                if (en && ext) begin
                    sched(n); set = 2;
                end else if (en && wdt) begin
                    irq_at = n;
                    if (grace == 0) begin
                        sched(n); set = 1;
                    end else begin
                        grace_last = c + longint'(grace);
                        idle_from  = BIG;
                    end
                end
            end else if (c <= grace_last) begin
                if (wdt) begin
                    irq_at = n; sched(n); set = 1;
                end else if (ack || !en) begin
                    idle_from = n; grace_last = -1;
                end else if (c == grace_last) begin
                    sched(n); set = 1;
                end
            end
            m_cause = (clr ? 0 : m_cause) | set;
        end
        cyc = n;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("irq",     32'(irq),     32'(irq_at == cyc));
            chk("sys_rst", 32'(sys_rst), 32'(cyc >= rs_start && cyc <= rs_end));
            chk("busy",    32'(busy),    32'(cyc < idle_from));
            chk("cause",   32'(cause),   32'(m_cause));
            chk("rst_cnt", 32'(cnt),     32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle wdt pulse; returns in cycle k+1 after sampling edge k.
    task automatic pulse();
        wdt = 1'b1;
        step(1);
        wdt = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_sys_rst", 32'(sys_rst), 0);
        chk("reset_cnt", 32'(cnt), 0);
        en = 1'b1;

        // Grace expiry, G=4 H=3
        grace = 4; hold = 3;
        pulse();
        chk("t1_irq_k1", 32'(irq), 1);
        chk("t1_busy_k1", 32'(busy), 1);
        step(1);
        chk("t1_irq_k2", 32'(irq), 0);
        step(2);
        chk("t1_rst_k4", 32'(sys_rst), 0);
        step(1);
        chk("t1_rst_k5", 32'(sys_rst), 1);
        chk("t1_cause", 32'(cause), 1);
        chk("t1_cnt", 32'(cnt), 1);
        step(2);
        chk("t1_rst_k7", 32'(sys_rst), 1);
        step(1);
        chk("t1_rst_k8", 32'(sys_rst), 0);
        chk("t1_busy_k9", 32'(busy), 1);
        step(2);
        chk("t1_busy_k10", 32'(busy), 0);

        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clear_cause", 32'(cause), 0);

        // Acknowledge at k+3
        grace = 10;
        pulse();
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t2_busy_k4", 32'(busy), 0);
        chk("t2_cause", 32'(cause), 0);
        chk("t2_cnt", 32'(cnt), 1);

        // Escalation by second pulse at k+5
        step(2);
        grace = 100;
        pulse();
        step(3);
        chk("t3_rst_k5", 32'(sys_rst), 0);
        pulse();
        chk("t3_rst_k6", 32'(sys_rst), 1);
        chk("t3_irq_k6", 32'(irq), 1);
        chk("t3_cnt", 32'(cnt), 2);
        step(5);
        chk("t3_idle", 32'(busy), 0);

        // G=0 H=0: one reset cycle
        grace = 0; hold = 0;
        pulse();
        chk("t4_rst_k1", 32'(sys_rst), 1);
        chk("t4_irq_k1", 32'(irq), 1);
        step(1);
        chk("t4_rst_k2", 32'(sys_rst), 0);
        chk("t4_busy_k2", 32'(busy), 1);
        step(2);
        chk("t4_busy_k4", 32'(busy), 0);
        chk("t4_cnt_sat", 32'(cnt), 3);

        // Ack coincident with expiry
        grace = 3; hold = 2;
        pulse();
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t5_rst", 32'(sys_rst), 0);
        chk("t5_busy", 32'(busy), 0);

        // Fourth reset with clear on the entry edge
        grace = 0;
        clr = 1'b1;
        pulse();
        clr = 1'b0;
        chk("t6_cause_kept", 32'(cause), 1);
        chk("t6_cnt_sat", 32'(cnt), 3);
        step(5);

        // Disabled: pulse ignored
        en = 1'b0;
        pulse();
        chk("t7_irq_dis", 32'(irq), 0);
        chk("t7_busy_dis", 32'(busy), 0);
        en = 1'b1;

`ifdef WDT_RST_SEQ_EXTREQ_EN
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        hold = 1;
        ext = 1'b1;
        pulse();
        chk("x_rst_k1", 32'(sys_rst), 1);
        chk("x_irq_k1", 32'(irq), 0);
        chk("x_cause", 32'(cause), 2);
        step(3);
        chk("x_rst_k4", 32'(sys_rst), 0);
        step(1);
        chk("x_rst_retrig", 32'(sys_rst), 1);
        ext = 1'b0;
        step(4);
`endif

        // Randomized activity
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 19) != 0);
            wdt = ($urandom_range(0, 11) == 0);
            ack = ($urandom_range(0, 14) == 0);
            clr = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) grace = GW'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) hold  = HW'($urandom_range(0, 5));
`ifdef WDT_RST_SEQ_EXTREQ_EN
            ext = ($urandom_range(0, 39) == 0);
`endif
            step(1);
        end
        wdt = 1'b0; ack = 1'b0; clr = 1'b0; rst = 1'b0; ext = 1'b0; en = 1'b1;
        step(30);

        // Reset in the middle of ASSERT
        grace = 0; hold = 6;
        pulse();
        chk("r_rst_k1", 32'(sys_rst), 1);
        step(2);
        rst = 1'b1;
        step(1);
        chk("r_sys_rst", 32'(sys_rst), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_cause", 32'(cause), 0);
        chk("r_cnt", 32'(cnt), 0);
        chk("r_irq", 32'(irq), 0);
        step(1);
        rst = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
